// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphony scheduler assigning note events to a pool of ADSR voices
module voice_allocator #(
    parameter int NUM_VOICES    = 4,
    parameter int NOTE_BITS     = 7,
    parameter int RETRIG_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ev_valid,
    output logic                            ev_ready,
    input  logic                            ev_on,
    input  logic [NOTE_BITS-1:0]            ev_note,
    input  logic [NUM_VOICES-1:0]           voice_idle,
    output logic [NUM_VOICES-1:0]           voice_gate,
    output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
    output logic                            voice_stolen
);

    // Width of a voice index / age rank, and of the re-gate gap counter.
    localparam int RB = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CW = (RETRIG_CYCLES > 0) ? $clog2(RETRIG_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECIDE,
        S_CUT
    } state_t;

    state_t               state;
    logic                 lat_on;
    logic [NOTE_BITS-1:0] lat_note;
    logic [RB-1:0]        rank [NUM_VOICES];
    logic [RB-1:0]        cut_voice;
    logic [CW-1:0]        cut_cnt;

    // Candidate search results, meaningful only while in DECIDE.
    logic [NOTE_BITS-1:0] cur_note;
    logic                 off_hit;
    logic [RB-1:0]        off_idx;
    logic                 same_hit;
    logic [RB-1:0]        same_idx;
    logic                 free_hit;
    logic [RB-1:0]        free_idx;
    logic                 rel_hit;
    logic [RB-1:0]        rel_idx;
    logic [RB-1:0]        rel_rank;
    logic                 gat_hit;
    logic [RB-1:0]        gat_idx;
    logic [RB-1:0]        gat_rank;
    logic [RB-1:0]        sel_idx;
    logic                 sel_steal;
    logic [RB-1:0]        sel_rank;

    // Scan the voice pool once for every selection rule, then pick by rule priority.
    always_comb begin
        cur_note  = '0;
        off_hit   = 1'b0;
        off_idx   = '0;
        same_hit  = 1'b0;
        same_idx  = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        rel_hit   = 1'b0;
        rel_idx   = '0;
        rel_rank  = '0;
        gat_hit   = 1'b0;
        gat_idx   = '0;
        gat_rank  = '0;
        sel_idx   = '0;
        sel_steal = 1'b0;

        // Descending scan so the lowest matching index is the one left standing.
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            cur_note = voice_note[i*NOTE_BITS +: NOTE_BITS];
            if (voice_gate[i] && (cur_note == lat_note)) begin
                off_hit = 1'b1;
                off_idx = RB'(i);
            end
            if ((cur_note == lat_note) && (voice_gate[i] || !voice_idle[i])) begin
                same_hit = 1'b1;
                same_idx = RB'(i);
            end
            if (!voice_gate[i] && voice_idle[i]) begin
                free_hit = 1'b1;
                free_idx = RB'(i);
            end
        end

        // Oldest-voice searches; ranks are unique so ties cannot occur.
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!voice_gate[i] && !voice_idle[i] && (!rel_hit || (rank[i] > rel_rank))) begin
                rel_hit  = 1'b1;
                rel_idx  = RB'(i);
                rel_rank = rank[i];
            end
            if (voice_gate[i] && (!gat_hit || (rank[i] > gat_rank))) begin
                gat_hit  = 1'b1;
                gat_idx  = RB'(i);
                gat_rank = rank[i];
            end
        end

        // When nothing else matches every voice is gated, so the steal always has a target.
        if (same_hit) begin
            sel_idx = same_idx;
        end else if (free_hit) begin
            sel_idx = free_idx;
        end else if (rel_hit) begin
            sel_idx = rel_idx;
        end else begin
            sel_idx   = gat_idx;
            sel_steal = 1'b1;
        end
    end

    assign sel_rank = rank[sel_idx];

    // Event FSM: accept, decide/assign voice, optional gate-low gap before re-gating.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ev_ready     <= 1'b1;
            voice_gate   <= '0;
            voice_note   <= '0;
            voice_stolen <= 1'b0;
            lat_on       <= 1'b0;
            lat_note     <= '0;
            cut_voice    <= '0;
            cut_cnt      <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                rank[i] <= RB'(i);
            end
        end else begin
            voice_stolen <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ev_valid) begin
                        lat_on   <= ev_on;
                        lat_note <= ev_note;
                        ev_ready <= 1'b0;
                        state    <= S_DECIDE;
                    end
                end

                S_DECIDE: begin
                    if (!lat_on) begin
                        if (off_hit) begin
                            voice_gate[off_idx] <= 1'b0;
                        end
                        ev_ready <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        voice_note[sel_idx*NOTE_BITS +: NOTE_BITS] <= lat_note;
                        // Chosen voice becomes youngest; everyone younger than it ages by one.
                        for (int j = 0; j < NUM_VOICES; j++) begin
                            if (RB'(j) == sel_idx) begin
                                rank[j] <= '0;
                            end else if (rank[j] < sel_rank) begin
                                rank[j] <= rank[j] + 1'b1;
                            end
                        end
                        if (voice_gate[sel_idx]) begin
                            // Already gated: drop the gate so the envelope sees a fresh edge.
                            voice_gate[sel_idx] <= 1'b0;
                            voice_stolen        <= sel_steal;
                            cut_voice           <= sel_idx;
                            cut_cnt             <= '0;
                            state               <= S_CUT;
                        end else begin
                            voice_gate[sel_idx] <= 1'b1;
                            ev_ready            <= 1'b1;
                            state               <= S_IDLE;
                        end
                    end
                end

                S_CUT: begin
                    if (cut_cnt == CW'(RETRIG_CYCLES - 1)) begin
                        voice_gate[cut_voice] <= 1'b1;
                        ev_ready              <= 1'b1;
                        state                 <= S_IDLE;
                    end else begin
                        cut_cnt <= cut_cnt + 1'b1;
                    end
                end

                default: begin
                    ev_ready <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - self-checking bench for voice_allocator
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int NB = 7;
    localparam int RC = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             ev_valid;
    logic             ev_ready;
    logic             ev_on;
    logic [NB-1:0]    ev_note;
    logic [NV-1:0]    voice_idle;
    logic [NV-1:0]    voice_gate;
    logic [NV*NB-1:0] voice_note;
    logic             voice_stolen;

    int errors = 0;
    int checks = 0;

    voice_allocator #(
        .NUM_VOICES   (NV),
        .NOTE_BITS    (NB),
        .RETRIG_CYCLES(RC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_on       (ev_on),
        .ev_note     (ev_note),
        .voice_idle  (voice_idle),
        .voice_gate  (voice_gate),
        .voice_note  (voice_note),
        .voice_stolen(voice_stolen)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] note_of(input int v);
        note_of = voice_note[v*NB +: NB];
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        ev_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Present one event, keep junk on ev_* while busy, and report what was seen.
    task automatic apply(input logic on, input logic [NB-1:0] note, input logic [NV-1:0] idle,
                         output logic stl_seen, output logic [NV-1:0] gate_dec, output int busy);
        int n;
        n = 0;
        while (!ev_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_before_event", 32'(ev_ready), 32'd1);
        ev_valid   = 1'b1;
        ev_on      = on;
        ev_note    = note;
        voice_idle = idle;
        @(posedge clk);
        #1;
        chk("ready_low_in_decide", 32'(ev_ready), 32'd0);
        ev_on   = 1'($urandom_range(0, 1));
        ev_note = NB'($urandom);
        @(posedge clk);
        #1;
        stl_seen = voice_stolen;
        gate_dec = voice_gate;
        busy     = 0;
        while (!ev_ready && busy < 50) begin
            @(posedge clk);
            #1;
            busy++;
        end
        ev_valid = 1'b0;
        chk("ready_after_event", 32'(ev_ready), 32'd1);
    endtask

    // Reference model: voice state arrays plus an age list (front = most recently assigned).
    bit            m_gate [NV];
    logic [NB-1:0] m_note [NV];
    int            age[$];

    task automatic model_reset();
        age.delete();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 1'b0;
            m_note[i] = '0;
            age.push_back(i);
        end
    endtask

    task automatic model_step(input logic on, input logic [NB-1:0] note, input logic [NV-1:0] idle,
                              output int v, output bit cut, output bit stl);
        v   = -1;
        cut = 1'b0;
        stl = 1'b0;
        if (!on) begin
            for (int i = 0; i < NV; i++)
                if (v < 0 && m_gate[i] && m_note[i] == note) v = i;
            if (v >= 0) m_gate[v] = 1'b0;
        end else begin
            for (int i = 0; i < NV; i++)
                if (v < 0 && m_note[i] == note && (m_gate[i] || !idle[i])) v = i;
            for (int i = 0; i < NV; i++)
                if (v < 0 && !m_gate[i] && idle[i]) v = i;
            for (int k = age.size() - 1; k >= 0; k--)
                if (v < 0 && !m_gate[age[k]] && !idle[age[k]]) v = age[k];
            for (int k = age.size() - 1; k >= 0; k--)
                if (v < 0 && m_gate[age[k]]) begin
                    v   = age[k];
                    stl = 1'b1;
                end
            cut       = m_gate[v];
            m_gate[v] = 1'b1;
            m_note[v] = note;
            for (int k = 0; k < age.size(); k++)
                if (age[k] == v) begin
                    age.delete(k);
                    break;
                end
            age.push_front(v);
        end
    endtask

    function automatic logic [NV-1:0] model_gates();
        for (int i = 0; i < NV; i++) model_gates[i] = m_gate[i];
    endfunction

    function automatic logic [NV*NB-1:0] model_notes();
        for (int i = 0; i < NV; i++) model_notes[i*NB +: NB] = m_note[i];
    endfunction

    typedef struct {
        bit            rst_first;
        bit            on;
        logic [NB-1:0] note;
        logic [NV-1:0] idle;
        int            voice;
        logic [NB-1:0] enote;
        logic [NV-1:0] gate;
        bit            cut;
        bit            stolen;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit on, int note, int idle, int voice, int enote,
                                int gate, bit cut, bit stolen);
        mk.rst_first = r;
        mk.on        = on;
        mk.note      = NB'(note);
        mk.idle      = NV'(idle);
        mk.voice     = voice;
        mk.enote     = NB'(enote);
        mk.gate      = NV'(gate);
        mk.cut       = cut;
        mk.stolen    = stolen;
    endfunction

    initial begin
        logic          stl_seen;
        logic [NV-1:0] gate_dec;
        int            busy;
        int            v;
        bit            cut;
        bit            stl;
        logic [NV-1:0] eg;

        ev_valid   = 1'b0;
        ev_on      = 1'b0;
        ev_note    = '0;
        voice_idle = '1;
        rst        = 1'b1;

        //           rst on note idle   v enote gate  cut st
        tbl.push_back(mk(1, 1, 60, 4'hF, 0, 60, 4'b0001, 0, 0));
        tbl.push_back(mk(0, 1, 62, 4'hF, 1, 62, 4'b0011, 0, 0));
        tbl.push_back(mk(0, 1, 64, 4'hF, 2, 64, 4'b0111, 0, 0));
        tbl.push_back(mk(0, 1, 65, 4'hF, 3, 65, 4'b1111, 0, 0));
        tbl.push_back(mk(0, 1, 67, 4'hF, 0, 67, 4'b1111, 1, 1));
        tbl.push_back(mk(0, 0, 62, 4'hF, 1, 62, 4'b1101, 0, 0));
        tbl.push_back(mk(0, 0, 61, 4'hF, 1, 62, 4'b1101, 0, 0));
        tbl.push_back(mk(0, 1, 70, 4'hF, 1, 70, 4'b1111, 0, 0));
        tbl.push_back(mk(0, 1, 64, 4'hF, 2, 64, 4'b1111, 1, 0));
        tbl.push_back(mk(0, 1, 72, 4'hF, 3, 72, 4'b1111, 1, 1));
        tbl.push_back(mk(0, 0, 67, 4'hF, 0, 67, 4'b1110, 0, 0));
        tbl.push_back(mk(0, 1, 74, 4'h0, 0, 74, 4'b1111, 0, 0));
        tbl.push_back(mk(0, 0, 74, 4'h0, 0, 74, 4'b1110, 0, 0));
        tbl.push_back(mk(0, 0, 70, 4'h0, 1, 70, 4'b1100, 0, 0));
        tbl.push_back(mk(0, 1, 76, 4'h0, 1, 76, 4'b1110, 0, 0));
        tbl.push_back(mk(1, 1, 60, 4'hF, 0, 60, 4'b0001, 0, 0));
        tbl.push_back(mk(0, 0, 60, 4'hF, 0, 60, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 1, 60, 4'hE, 0, 60, 4'b0001, 0, 0));
        tbl.push_back(mk(0, 1, 60, 4'hE, 0, 60, 4'b0001, 1, 0));
        tbl.push_back(mk(0, 0, 60, 4'hE, 0, 60, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 1, 70, 4'hE, 1, 70, 4'b0010, 0, 0));
        tbl.push_back(mk(1, 1, 50, 4'h0, 3, 50, 4'b1000, 0, 0));

        do_reset();
        chk("reset_gate", 32'(voice_gate), 32'd0);
        chk("reset_note", 32'(voice_note), 32'd0);
        chk("reset_stolen", 32'(voice_stolen), 32'd0);
        chk("reset_ready", 32'(ev_ready), 32'd1);

        foreach (tbl[k]) begin
            if (tbl[k].rst_first) do_reset();
            apply(tbl[k].on, tbl[k].note, tbl[k].idle, stl_seen, gate_dec, busy);
            chk($sformatf("tbl%0d_stolen", k), 32'(stl_seen), 32'(tbl[k].stolen));
            if (tbl[k].cut) begin
                chk($sformatf("tbl%0d_cut_low", k), 32'(gate_dec[tbl[k].voice]), 32'd0);
                chk($sformatf("tbl%0d_cut_len", k), 32'(busy), 32'(RC));
            end else begin
                chk($sformatf("tbl%0d_gate_early", k), 32'(gate_dec), 32'(tbl[k].gate));
                chk($sformatf("tbl%0d_busy", k), 32'(busy), 32'd0);
            end
            chk($sformatf("tbl%0d_gate", k), 32'(voice_gate), 32'(tbl[k].gate));
            chk($sformatf("tbl%0d_note", k), 32'(note_of(tbl[k].voice)), 32'(tbl[k].enote));
            chk($sformatf("tbl%0d_pulse_end", k), 32'(voice_stolen), 32'd0);
        end

        // Reset while a re-gate gap is in progress.
        do_reset();
        apply(1'b1, NB'(60), 4'hF, stl_seen, gate_dec, busy);
        ev_valid   = 1'b1;
        ev_on      = 1'b1;
        ev_note    = NB'(60);
        voice_idle = 4'hF;
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("cut_gate_low", 32'(voice_gate), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_cut_gate", 32'(voice_gate), 32'd0);
        chk("rst_cut_note", 32'(voice_note), 32'd0);
        chk("rst_cut_ready", 32'(ev_ready), 32'd1);
        chk("rst_cut_stolen", 32'(voice_stolen), 32'd0);
        repeat (RC + 1) @(posedge clk);
        #1;
        chk("rst_cut_no_regate", 32'(voice_gate), 32'd0);
        apply(1'b1, NB'(61), 4'hF, stl_seen, gate_dec, busy);
        chk("rst_cut_next_gate", 32'(voice_gate), 32'b0001);
        chk("rst_cut_next_note", 32'(note_of(0)), 32'd61);

        // Randomized events against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 300; n++) begin
            logic          r_on;
            logic [NB-1:0] r_note;
            logic [NV-1:0] r_idle;
            r_on   = ($urandom_range(0, 9) < 7);
            r_note = NB'(60 + $urandom_range(0, 5));
            r_idle = NV'($urandom);
            model_step(r_on, r_note, r_idle, v, cut, stl);
            apply(r_on, r_note, r_idle, stl_seen, gate_dec, busy);
            eg = model_gates();
            if (cut) eg[v] = 1'b0;
            chk($sformatf("rnd%0d_stolen", n), 32'(stl_seen), 32'(stl));
            chk($sformatf("rnd%0d_gate_early", n), 32'(gate_dec), 32'(eg));
            chk($sformatf("rnd%0d_busy", n), 32'(busy), cut ? 32'(RC) : 32'd0);
            chk($sformatf("rnd%0d_gate", n), 32'(voice_gate), 32'(model_gates()));
            chk($sformatf("rnd%0d_note", n), 32'(voice_note), 32'(model_notes()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphony scheduler: shares a pool of NUM_VOICES adsr_generator voices between incoming note-on/note-off events.
- Per event, selects a voice and drives its gate and note number, stealing voices when the pool is exhausted.
- Forces a gate-low gap before re-gating an already-gated voice so the ADSR sees a clean rising edge.
- Sits between the note-event source (button/serial decoder) and the voice array feeding the mixer.

Parameters:
- NUM_VOICES, 4, number of voices managed (2..8).
- NOTE_BITS, 7, width of note number.
- RETRIG_CYCLES, 2, clock cycles gate is held low before re-gating a gated voice (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- ev_valid  input  1  event present.
- ev_ready  output  1  event accepted on clk edge when ev_valid && ev_ready.
- ev_on  input  1  1 = note-on, 0 = note-off.
- ev_note  input  NOTE_BITS  note number of event.
- voice_idle  input  NUM_VOICES  per voice, 1 when that voice's amplitude == 0 (top level compares each adsr_generator amplitude to 0).
- voice_gate  output  NUM_VOICES  per-voice gate to adsr_generator.
- voice_note  output  NUM_VOICES*NOTE_BITS  per-voice note number; voice i at bits [i*NOTE_BITS +: NOTE_BITS].
- voice_stolen  output  1  one-cycle pulse when a gated voice with a different note is reassigned.

Behaviour:
- Reset: voice_gate=0, voice_note=0, voice_stolen=0, ev_ready=1, state IDLE, rank[i]=i. Reset mid-operation aborts any pending event; no output changes after rst except the reset values.
- Registers:
  - ev_on and ev_note latched at accept.
  - rank[i]: ages forming a permutation of 0..NUM_VOICES-1; higher = older.
- States:
  - IDLE: ev_ready=1. On accept -> DECIDE.
  - DECIDE: ev_ready=0; one cycle; selects voice v, then goes to CUT or back to IDLE.
  - CUT: ev_ready=0; counts RETRIG_CYCLES cycles.
- Note-off in DECIDE: match = lowest index i with voice_gate[i]=1 and voice_note[i]=ev_note. If found, voice_gate[i]<=0 on the DECIDE edge; -> IDLE. If none found, no change; -> IDLE.
- Note-on selection priority in DECIDE (first rule that matches wins):
  1. Same note: lowest i with voice_note[i]=ev_note and (voice_gate[i] or !voice_idle[i]).
  2. Free voice: lowest i with !voice_gate[i] and voice_idle[i].
  3. Releasing voice: !voice_gate[i] and !voice_idle[i], highest rank.
  4. Steal: gated voice with highest rank.
- Note-on with voice_gate[v]=0:
  - On the DECIDE edge: voice_note[v]<=ev_note and voice_gate[v]<=1.
  - -> IDLE.
- Note-on with voice_gate[v]=1 (rules 1 or 4):
  - On the DECIDE edge: voice_gate[v]<=0 and voice_note[v]<=ev_note.
  - -> CUT. After RETRIG_CYCLES cycles in CUT, voice_gate[v]<=1 and -> IDLE.
  - voice_stolen pulses on the DECIDE edge only for rule 4.
- Rank update on every note-on, on the DECIDE edge: rank[v]<=0; every j with rank[j] < old rank[v] increments. Ranks stay a permutation.
- Timing:
  - Gate rises 2 edges after accept without a cut, and 2+RETRIG_CYCLES edges after accept with a cut.
  - Throughput: one event per 2 cycles (no cut) or per 2+RETRIG_CYCLES cycles (cut).
- Other voices' gates and notes are never disturbed by an event.
- voice_idle is sampled only in DECIDE; ev_* are ignored while ev_ready=0.

Test Plan:
- Reset, then note-on 60 with all voice_idle=1 -> voice 0: note 60, gate high 2 edges after accept. ev_ready low for 1 cycle. voice_stolen=0.
- Note-ons 60, 62, 64, 65 (all idle) -> voices 0..3 gated with those notes. A fifth note-on 67 -> voice 0 (oldest, rank 3) gated low for 2 cycles, then high with note 67. voice_stolen pulses once.
- Note-on 60 then note-off 60 -> voice 0 gate low 2 edges after the off is accepted. A further note-off 61 -> no output change, ev_ready back to 1 after 1 cycle.
- Voice 0 releasing (gate=0, voice_idle[0]=0, note 60) and voice 1 idle; note-on 60 -> voice 0 reused, gate rises with no cut. Note-on 70 instead -> voice 1 chosen (free beats releasing).
- Note-on 60 while voice 0 is already gated on 60 -> gate low exactly RETRIG_CYCLES=2 cycles then high. Note unchanged. voice_stolen=0.
- Assert rst during CUT -> next cycle all gates 0, notes 0, ev_ready=1, rank restored to 0..3. A subsequent note-on lands on voice 0.
